// File: rtl/sp_ram_be_clr.sv
// Single-port synchronous RAM with per-byte write enables, selectable read-during-write
// behaviour, an optional output register and a post-reset clear pass over the whole array.
module sp_ram_be_clr #(
  parameter int DATA_W     = 16,
  parameter int BYTE_W     = 8,
  parameter int ADDR_W     = 6,
  parameter int RDW_MODE   = 0,
  parameter int OUT_REG    = 0,
  parameter int CLR_ON_RST = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       write_enable,
  input  logic [DATA_W/BYTE_W-1:0]   be,
  input  logic [ADDR_W-1:0]          address,
  input  logic [DATA_W-1:0]          data,
  output logic [DATA_W-1:0]          q,
  output logic                       q_valid,
  output logic                       busy
);

  localparam int NB    = DATA_W / BYTE_W;
  localparam int DEPTH = 2 ** ADDR_W;

  if (DATA_W % BYTE_W != 0) begin : g_bad_width
    $error("sp_ram_be_clr: DATA_W must be a multiple of BYTE_W");
  end

  typedef enum logic {CLEAR, READY} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   cnt;
  logic                busy_r;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                acc;
  logic                do_clr;
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   wr_word;

  logic [DATA_W-1:0]   q_p0;
  logic                vld_p0;

  function automatic logic [DATA_W-1:0] merge_lanes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [NB-1:0]     lanes
  );
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int i = 0; i < NB; i++) begin
      if (lanes[i]) r[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
    end
    return r;
  endfunction

  always_comb begin
    acc     = rst_n && en && (state == READY);
    do_clr  = rst_n && (state == CLEAR);
    rd_word = mem[address];
    wr_word = merge_lanes(rd_word, data, be);
  end

  // Control: clear sequencer walks every address once, then hands over to READY
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= (CLR_ON_RST != 0) ? CLEAR : READY;
      cnt    <= '0;
      busy_r <= (CLR_ON_RST != 0);
    end else if (state == CLEAR) begin
      cnt <= cnt + 1'b1;
      if (&cnt) begin
        state  <= READY;
        busy_r <= 1'b0;
      end
    end
  end

  // Array: not touched by rst_n, only by the clear pass or a qualified write
  always_ff @(posedge clk) begin
    if (do_clr) begin
      mem[cnt] <= '0;
    end else if (acc && write_enable) begin
      mem[address] <= wr_word;
    end
  end

  // Stage p0: read word (or merged word in write-first mode) captured with its strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_p0   <= '0;
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= acc;
      if (acc) q_p0 <= (write_enable && (RDW_MODE != 0)) ? wr_word : rd_word;
    end
  end

  // Stage p1: optional output register, holds its value between strobes
  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_W-1:0] q_p1;
    logic              vld_p1;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        q_p1   <= '0;
        vld_p1 <= 1'b0;
      end else begin
        vld_p1 <= vld_p0;
        if (vld_p0) q_p1 <= q_p0;
      end
    end

    assign q       = q_p1;
    assign q_valid = vld_p1;
  end else begin : g_noreg
    assign q       = q_p0;
    assign q_valid = vld_p0;
  end

  assign busy = busy_r;

endmodule

// File: tb/tb_sp_ram_be_clr.sv
// Bench for sp_ram_be_clr: three configurations share one stimulus stream and are
// checked every cycle against a timestamped behavioural model plus literal expectations.
module tb_sp_ram_be_clr;

  localparam int NI    = 3;
  localparam int DW    = 16;
  localparam int AW    = 6;
  localparam int DEPTH = 64;
  localparam int LAT [NI] = '{1, 2, 1};
  localparam int RDW [NI] = '{0, 1, 0};
  localparam int CLR [NI] = '{1, 1, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          en;
  logic          we;
  logic [1:0]    be;
  logic [AW-1:0] address;
  logic [DW-1:0] data;

  logic [DW-1:0] dq [NI];
  logic          dv [NI];
  logic          db [NI];

  sp_ram_be_clr #(.DATA_W(16), .BYTE_W(8), .ADDR_W(6), .RDW_MODE(0), .OUT_REG(0), .CLR_ON_RST(1)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .write_enable(we), .be(be), .address(address),
    .data(data), .q(dq[0]), .q_valid(dv[0]), .busy(db[0]));

  sp_ram_be_clr #(.DATA_W(16), .BYTE_W(8), .ADDR_W(6), .RDW_MODE(1), .OUT_REG(1), .CLR_ON_RST(1)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .write_enable(we), .be(be), .address(address),
    .data(data), .q(dq[1]), .q_valid(dv[1]), .busy(db[1]));

  sp_ram_be_clr #(.DATA_W(16), .BYTE_W(8), .ADDR_W(6), .RDW_MODE(0), .OUT_REG(0), .CLR_ON_RST(0)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .write_enable(we), .be(be), .address(address),
    .data(data), .q(dq[2]), .q_valid(dv[2]), .busy(db[2]));

  int tests = 0;
  int fails = 0;

  // Model state: word array (X = never written), remaining clear cycles,
  // and a small table of results scheduled by the edge at which they appear.
  logic [DW-1:0] mm   [NI][DEPTH];
  int            clr_left [NI];
  logic [DW-1:0] held [NI];
  bit            vexp [NI];
  bit            pv   [NI][4];
  logic [DW-1:0] pval [NI][4];
  longint        ncyc = 0;
  bit            started = 1'b0;

  initial begin : model
    logic [DW-1:0] old_w;
    logic [DW-1:0] new_w;
    logic [DW-1:0] res;
    int            slot;
    forever begin
      @(posedge clk);
      ncyc++;
      for (int i = 0; i < NI; i++) begin
        if (rst_n !== 1'b1) begin
          clr_left[i] = (CLR[i] != 0) ? DEPTH : 0;
          held[i] = '0;
          vexp[i] = 1'b0;
          for (int k = 0; k < 4; k++) pv[i][k] = 1'b0;
        end else begin
          if (clr_left[i] > 0) begin
            clr_left[i]--;
            if (clr_left[i] == 0) begin
              for (int a = 0; a < DEPTH; a++) mm[i][a] = '0;
            end
          end else if (en) begin
            old_w = mm[i][address];
            new_w = old_w;
            if (we) begin
              for (int l = 0; l < 2; l++) begin
                if (be[l]) new_w[l*8 +: 8] = data[l*8 +: 8];
              end
              mm[i][address] = new_w;
              res = (RDW[i] != 0) ? new_w : old_w;
            end else begin
              res = old_w;
            end
            slot = int'((ncyc + longint'(LAT[i]) - 1) % 4);
            pv[i][slot]   = 1'b1;
            pval[i][slot] = res;
          end
          slot = int'(ncyc % 4);
          vexp[i] = pv[i][slot];
          if (pv[i][slot]) begin
            held[i]     = pval[i][slot];
            pv[i][slot] = 1'b0;
          end
        end
      end
      if (rst_n === 1'b0) started = 1'b1;
    end
  end

  function automatic bit xmatch(input logic [DW-1:0] act, input logic [DW-1:0] exp);
    for (int b = 0; b < DW; b++) begin
      if (exp[b] !== 1'bx && act[b] !== exp[b]) return 1'b0;
    end
    return 1'b1;
  endfunction

  initial begin : compare
    forever begin
      @(negedge clk);
      if (started) begin
        for (int i = 0; i < NI; i++) begin
          tests++;
          if (db[i] !== (clr_left[i] > 0)) begin
            fails++;
            $display("FAIL busy[%0d] cyc %0d: got %b want %b", i, ncyc, db[i], (clr_left[i] > 0));
          end
          tests++;
          if (dv[i] !== vexp[i]) begin
            fails++;
            $display("FAIL q_valid[%0d] cyc %0d: got %b want %b", i, ncyc, dv[i], vexp[i]);
          end
          tests++;
          if (!xmatch(dq[i], held[i])) begin
            fails++;
            $display("FAIL q[%0d] cyc %0d: got %h want %h", i, ncyc, dq[i], held[i]);
          end
        end
      end
    end
  end

  task automatic chk16(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic acc(input logic w, input logic [1:0] b, input logic [AW-1:0] a, input logic [DW-1:0] d);
    en = 1'b1; we = w; be = b; address = a; data = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    en = 1'b0; we = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int k;
    rst_n = 1'b0; en = 1'b0; we = 1'b0; be = 2'b00; address = '0; data = '0;
    repeat (2) @(negedge clk);
    chkb("reset busy a", db[0], 1'b1);
    chkb("reset busy c", db[2], 1'b0);
    chk16("reset q a", dq[0], 16'h0000);
    chkb("reset q_valid b", dv[1], 1'b0);

    // Clear pass: a write issued during it must be ignored by the clearing instances
    rst_n = 1'b1;
    acc(1'b1, 2'b11, 6'd5, 16'hBEEF);
    chkb("masked q_valid a", dv[0], 1'b0);
    idle(18);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    k = 0;
    while (k < 200) begin
      @(negedge clk);
      k++;
      if (db[0] == 1'b0) break;
    end
    chk16("busy cycles after release", 16'(k), 16'd64);
    chkb("busy c after clear", db[2], 1'b0);

    acc(1'b0, 2'b00, 6'd5, 16'h0000);
    chk16("read 5 after clear a", dq[0], 16'h0000);
    chk16("read 5 no clear c", dq[2], 16'hBEEF);
    acc(1'b0, 2'b00, 6'd16, 16'h0000);
    chk16("clear rd16 a", dq[0], 16'h0000);
    acc(1'b0, 2'b00, 6'd12, 16'h0000);
    chk16("clear rd12 a", dq[0], 16'h0000);
    acc(1'b0, 2'b00, 6'd7, 16'h0000);
    chk16("clear rd7 a", dq[0], 16'h0000);
    chkb("clear rd7 valid a", dv[0], 1'b1);
    idle(2);

    // Full-word writes, then back-to-back readback
    acc(1'b1, 2'b11, 6'd16, 16'h1818);
    chk16("rdw0 write old a", dq[0], 16'h0000);
    acc(1'b1, 2'b11, 6'd12, 16'h2929);
    chk16("rdw1 write new b", dq[1], 16'h1818);
    acc(1'b1, 2'b11, 6'd7, 16'hAAAA);
    idle(2);
    acc(1'b0, 2'b11, 6'd16, 16'hFFFF);
    chk16("rd16 a", dq[0], 16'h1818);
    acc(1'b0, 2'b00, 6'd12, 16'h0000);
    chk16("rd12 a", dq[0], 16'h2929);
    chk16("rd16 b lat2", dq[1], 16'h1818);
    acc(1'b0, 2'b00, 6'd7, 16'h0000);
    chk16("rd7 a", dq[0], 16'hAAAA);
    chk16("rd12 b lat2", dq[1], 16'h2929);
    chkb("stream valid b", dv[1], 1'b1);
    idle(1);
    chkb("idle valid a", dv[0], 1'b0);
    chk16("idle hold a", dq[0], 16'hAAAA);
    chk16("rd7 b lat2", dq[1], 16'hAAAA);
    chkb("rd7 valid b", dv[1], 1'b1);
    idle(1);
    chkb("drained valid b", dv[1], 1'b0);

    // Byte-lane enables: low lane only, then an all-lanes-off no-op write
    acc(1'b1, 2'b01, 6'd16, 16'h55AA);
    acc(1'b0, 2'b11, 6'd16, 16'hFFFF);
    chk16("be=01 merge a", dq[0], 16'h18AA);
    acc(1'b1, 2'b00, 6'd16, 16'hFFFF);
    acc(1'b0, 2'b00, 6'd16, 16'h0000);
    chk16("be=00 no-op a", dq[0], 16'h18AA);

    // Read-during-write
    acc(1'b1, 2'b11, 6'd12, 16'h1234);
    chk16("rdw0 old word a", dq[0], 16'h2929);
    acc(1'b0, 2'b00, 6'd12, 16'h0000);
    chk16("after rdw read a", dq[0], 16'h1234);
    chk16("rdw1 new word b", dq[1], 16'h1234);
    idle(1);
    chk16("after rdw read b", dq[1], 16'h1234);
    chk16("after rdw read c", dq[2], 16'h1234);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sp_ram_be_clr.md
Name: sp_ram_be_clr

Overview:
Parametrised single-port synchronous RAM: the next generation of the team's 8-bit x 64 single-port RAM. Adds per-byte write enables, selectable read-during-write behaviour, an optional output pipeline register and a post-reset clear state machine that zeroes the whole array. It serves as the general on-chip storage primitive for the team's mini-project datapaths.

Parameters:
DATA_W, 16, word width in bits; must be a multiple of BYTE_W.
BYTE_W, 8, byte-lane width in bits.
ADDR_W, 6, address width in bits. DEPTH = 2**ADDR_W words.
RDW_MODE, 0, read-during-write behaviour. 0 = read-first (q returns old word). 1 = write-first (q returns new merged word).
OUT_REG, 0, extra output register stage. 0 gives read latency 1; 1 gives read latency 2.
CLR_ON_RST, 1, when 1, the array is zeroed after reset. When 0, no clear pass runs and the array is not initialised.

Ports:
clk  in  1  single clock; all logic updates on the rising edge.
rst_n  in  1  reset. It is synchronous and active-low.
en  in  1  access request, sampled on the rising edge.
write_enable  in  1  1 = write access, 0 = read access (qualified by en).
be  in  DATA_W/BYTE_W  byte-lane write enables; be[i] selects bits [i*BYTE_W +: BYTE_W].
address  in  ADDR_W  word address.
data  in  DATA_W  write data.
q  out  DATA_W  read data.
q_valid  out  1  1-cycle strobe, aligned with new q.
busy  out  1  high while the clear pass is running; accesses are ignored.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - q=0, q_valid=0, all pipeline registers cleared, clear counter=0.
  - FSM goes to CLEAR if CLR_ON_RST=1, otherwise to READY.
  - busy=1 while rst_n=0 if CLR_ON_RST=1, otherwise busy=0.
  - The array contents are not reset by rst_n itself.
- FSM states: CLEAR and READY.
  - CLEAR:
    - Each cycle after rst_n returns high, writes 0 to mem[cnt] and increments cnt.
    - At cnt=DEPTH-1, the final word is written and the FSM moves to READY.
    - busy is high for exactly DEPTH cycles after the first edge with rst_n=1.
    - en is masked: no writes, no reads, q_valid=0, q holds 0.
  - READY: busy=0 and accesses are serviced.
- Reset asserted mid-clear: cnt returns to 0 and the full pass restarts after release.
- Write (READY, en=1, write_enable=1):
  - Only lanes with be[i]=1 are updated; other lanes keep their old value. be=0 is a legal no-op.
  - q is updated per RDW_MODE with a q_valid strobe:
    - RDW_MODE=0: q = word before the write.
    - RDW_MODE=1: q = merged word after the write.
- Read (READY, en=1, write_enable=0): q = mem[address] with a q_valid strobe.
- Latency:
  - OUT_REG=0: q and q_valid are valid after the same edge that samples the request (visible in the next cycle).
  - OUT_REG=1: one extra cycle.
  - Full throughput of one access per cycle; back-to-back accesses stream with no bubbles.
- en=0 or busy=1: q holds its last value and q_valid=0 (with OUT_REG=1, after the pipeline drains).
- data and be are ignored on reads; write_enable, be, address and data are don't-care when en=0.
- Address is a full ADDR_W range with no out-of-range case. Reads of any address are defined after the clear pass, and undefined (X) when CLR_ON_RST=0 and the address was never written.

Test Plan:
- Reset/clear (defaults): rst_n=0 for 2 cycles, then 1 -> busy=1 for exactly 64 cycles, then 0; reads of addr 16, 12, 7 -> q=16'h0000 with a q_valid pulse each.
- Write/readback: write 16'h1818@16, 16'h2929@12, 16'hAAAA@7 with be=2'b11, then read 16, 12, 7 back-to-back -> q=1818, 2929, AAAA on consecutive cycles, each 1 cycle after its request, q_valid high for 3 cycles.
- Byte enables: mem[16]=16'h1818; write 16'h55AA with be=2'b01 -> readback 16'h18AA. Write with be=2'b00 -> 16'h18AA unchanged.
- Read-during-write: mem[12]=16'h2929; write 16'h1234@12 -> RDW_MODE=0 gives q=16'h2929, RDW_MODE=1 gives q=16'h1234; subsequent read gives 16'h1234 in both modes.
- Busy masking and mid-clear reset: during the clear pass, write 16'hBEEF@5 -> ignored, q_valid=0, and after clear mem[5]=0. Pulse rst_n low 20 cycles into the clear -> busy stays high for 64 cycles after the final release.
- Output register: OUT_REG=1, read addr 16, 12, 7 back-to-back -> q/q_valid appear 2 cycles after each request, streamed one per cycle. With CLR_ON_RST=0, busy=0 immediately after reset.
